// File: rtl/adat_decoder.sv
// ADAT receive framer: hunts for sync, extracts user bits and 8x24-bit samples,
// and writes them bit by bit into a circular frame RAM, committing good frames.
module adat_decoder #(
   parameter int CIRC_BUF_BITS = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       bit_i,
   input  logic                       bit_valid_i,
   output logic                       ram_we_o,
   output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
   output logic                       ram_data_o,
   output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
   output logic [3:0]                 user_bits_o,
   output logic                       locked_o,
   output logic                       frame_error_o
);

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_USER_BITS,
      ST_SAMPLES
   } state_t;

   localparam logic [3:0] SYNC_ZEROS = 4'd10;
   localparam logic [3:0] RUN_MAX    = 4'd15;
   localparam logic [4:0] LAST_BIT   = 5'd23;
   localparam logic [2:0] LAST_CHAN  = 3'd7;
   localparam logic [2:0] LAST_POS   = 3'd4;

   state_t                   state_reg;
   logic [3:0]               zero_run_reg;
   logic [2:0]               nib_pos_reg;
   logic [2:0]               channel_reg;
   logic [4:0]               bit_idx_reg;
   logic [3:0]               user_stage_reg;
   logic [CIRC_BUF_BITS-1:0] write_frame_reg;

   logic framing_violation;
   logic last_sample_bit;

   // Every nibble in user or sample sections opens with a mandatory 1.
   assign framing_violation = bit_valid_i && (state_reg != ST_HUNT) &&
                              (nib_pos_reg == 3'd0) && !bit_i;
   assign last_sample_bit   = (channel_reg == LAST_CHAN) && (bit_idx_reg == LAST_BIT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg             <= ST_HUNT;
         zero_run_reg          <= '0;
         nib_pos_reg           <= '0;
         channel_reg           <= '0;
         bit_idx_reg           <= '0;
         user_stage_reg        <= '0;
         write_frame_reg       <= '0;
         ram_we_o              <= 1'b0;
         ram_write_addr_o      <= '0;
         ram_data_o            <= 1'b0;
         last_good_frame_idx_o <= '0;
         user_bits_o           <= '0;
         locked_o              <= 1'b0;
         frame_error_o         <= 1'b0;
      end else begin
         ram_we_o      <= 1'b0;
         frame_error_o <= 1'b0;
         if (framing_violation) begin
            // The partial slot is simply overwritten by the next frame.
            frame_error_o <= 1'b1;
            locked_o      <= 1'b0;
            state_reg     <= ST_HUNT;
            zero_run_reg  <= 4'd1;
         end else if (bit_valid_i) begin
            unique case (state_reg)
               ST_HUNT: begin
                  if (bit_i) begin
                     zero_run_reg <= '0;
                     if (zero_run_reg >= SYNC_ZEROS) begin
                        state_reg   <= ST_USER_BITS;
                        nib_pos_reg <= 3'd1;
                     end
                  end else if (zero_run_reg != RUN_MAX) begin
                     zero_run_reg <= zero_run_reg + 4'd1;
                     if (zero_run_reg == RUN_MAX - 4'd1) begin
                        locked_o <= 1'b0;
                     end
                  end
               end

               ST_USER_BITS: begin
                  if (nib_pos_reg == 3'd0) begin
                     nib_pos_reg <= 3'd1;
                  end else begin
                     user_stage_reg <= {bit_i, user_stage_reg[3:1]};
                     if (nib_pos_reg == LAST_POS) begin
                        state_reg   <= ST_SAMPLES;
                        nib_pos_reg <= 3'd0;
                        channel_reg <= '0;
                        bit_idx_reg <= '0;
                     end else begin
                        nib_pos_reg <= nib_pos_reg + 3'd1;
                     end
                  end
               end

               ST_SAMPLES: begin
                  if (nib_pos_reg == 3'd0) begin
                     nib_pos_reg <= 3'd1;
                  end else begin
                     ram_we_o         <= 1'b1;
                     ram_data_o       <= bit_i;
                     ram_write_addr_o <= {write_frame_reg, channel_reg, bit_idx_reg};
                     nib_pos_reg      <= (nib_pos_reg == LAST_POS) ? 3'd0 : nib_pos_reg + 3'd1;
                     if (bit_idx_reg == LAST_BIT) begin
                        bit_idx_reg <= '0;
                        channel_reg <= channel_reg + 3'd1;
                     end else begin
                        bit_idx_reg <= bit_idx_reg + 5'd1;
                     end
                     if (last_sample_bit) begin
                        last_good_frame_idx_o <= write_frame_reg;
                        user_bits_o           <= user_stage_reg;
                        write_frame_reg       <= write_frame_reg + 1'b1;
                        locked_o              <= 1'b1;
                        state_reg             <= ST_HUNT;
                        zero_run_reg          <= '0;
                     end
                  end
               end

               default: begin
                  state_reg    <= ST_HUNT;
                  zero_run_reg <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adat_decoder.sv
// Scoreboard bench for adat_decoder: expected RAM writes are queued as bits are
// driven and popped as the decoder emits them; commit state is checked per frame.
module tb_adat_decoder;

   localparam int CBB = 3;
   localparam int AW  = CBB + 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           bit_in;
   logic           bit_valid;
   logic           ram_we;
   logic [AW-1:0]  ram_addr;
   logic           ram_data;
   logic [CBB-1:0] last_good;
   logic [3:0]     user_bits;
   logic           locked;
   logic           frame_error;

   int n_checks = 0;
   int n_pass   = 0;
   int err_seen = 0;

   logic [AW:0]    exp_q[$];
   logic [CBB-1:0] exp_slot;

   adat_decoder #(.CIRC_BUF_BITS(CBB)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .bit_i                 (bit_in),
      .bit_valid_i           (bit_valid),
      .ram_we_o              (ram_we),
      .ram_write_addr_o      (ram_addr),
      .ram_data_o            (ram_data),
      .last_good_frame_idx_o (last_good),
      .user_bits_o           (user_bits),
      .locked_o              (locked),
      .frame_error_o         (frame_error)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [AW:0] e;
      if (frame_error === 1'b1) err_seen++;
      if (ram_we === 1'b1) begin
         check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("wr_addr", 32'(ram_addr), 32'(e[AW:1]));
            check_eq("wr_data", 32'(ram_data), 32'(e[0]));
         end
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk);
      bit_in    = b;
      bit_valid = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      bit_in    = 1'b0;
      bit_valid = 1'b0;
   endtask

   // Sends 10 zeros, user nibble, samples, trailing sync 1. stop_ch/stop_nib
   // abort before that nibble; with corrupt set a 0 framing bit is sent first.
   task automatic send_frame(input logic [3:0] user, input int frame_no,
                             input int stop_ch, input int stop_nib, input bit corrupt);
      logic [23:0]   s;
      logic [AW-1:0] a;
      int            bi;
      repeat (10) send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 0; i < 4; i++) send_bit(user[i]);
      for (int ch = 0; ch < 8; ch++) begin
         s = 24'hA00000 + 24'(ch) + (24'(frame_no) << 8);
         for (int nib = 0; nib < 6; nib++) begin
            if (ch == stop_ch && nib == stop_nib) begin
               if (corrupt) send_bit(1'b0);
               return;
            end
            send_bit(1'b1);
            for (int k = 0; k < 4; k++) begin
               bi = nib * 4 + k;
               a  = {exp_slot, 3'(ch), 5'(bi)};
               exp_q.push_back({a, s[bi]});
               send_bit(s[bi]);
            end
         end
      end
      send_bit(1'b1);
      exp_slot = exp_slot + 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]     u;
      logic [CBB-1:0] slot;
      rst       = 1'b1;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      exp_slot  = '0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_we",        32'(ram_we),      32'd0);
      check_eq("rst_addr",      32'(ram_addr),    32'd0);
      check_eq("rst_data",      32'(ram_data),    32'd0);
      check_eq("rst_last_good", 32'(last_good),   32'd0);
      check_eq("rst_user",      32'(user_bits),   32'd0);
      check_eq("rst_locked",    32'(locked),      32'd0);
      check_eq("rst_error",     32'(frame_error), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Nine back-to-back frames: slot index walks 0..7 then wraps to 0.
      for (int f = 0; f < 9; f++) begin
         u    = (f == 0) ? 4'b1101 : 4'($urandom_range(0, 15));
         slot = exp_slot;
         send_frame(u, f, -1, 0, 1'b0);
         #1;
         check_eq("commit_idx",    32'(last_good),    32'(slot));
         check_eq("commit_user",   32'(user_bits),    32'(u));
         check_eq("commit_locked", 32'(locked),       32'd1);
         check_eq("commit_drain",  32'(exp_q.size()), 32'd0);
         $display("frame %0d committed slot %0d user %h", f, last_good, user_bits);
      end

      // Corrupt framing bit of ch3 nibble 2: error pulse, no commit.
      send_frame(4'h5, 9, 3, 2, 1'b1);
      idle();
      #1;
      check_eq("ferr_pulse",  32'(frame_error), 32'd1);
      check_eq("ferr_locked", 32'(locked),      32'd0);
      check_eq("ferr_idx",    32'(last_good),   32'd0);
      idle();
      #1;
      check_eq("ferr_single", 32'(frame_error), 32'd0);
      slot = exp_slot;
      send_frame(4'h6, 10, -1, 0, 1'b0);
      #1;
      check_eq("recover_idx",    32'(last_good), 32'(slot));
      check_eq("recover_slot",   32'(slot),      32'd1);
      check_eq("recover_locked", 32'(locked),    32'd1);
      check_eq("recover_user",   32'(user_bits), 32'h6);
      $display("frame 10 committed slot %0d after framing error", last_good);

      // Nine zeros then 1 is not sync: nothing written, nothing changes.
      repeat (9) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      repeat (3) idle();
      #1;
      check_eq("nine_drain",  32'(exp_q.size()), 32'd0);
      check_eq("nine_locked", 32'(locked),       32'd1);
      check_eq("nine_idx",    32'(last_good),    32'd1);
      slot = exp_slot;
      send_frame(4'hA, 11, -1, 0, 1'b0);
      #1;
      check_eq("after_nine_idx",  32'(last_good), 32'(slot));
      check_eq("after_nine_user", 32'(user_bits), 32'hA);
      $display("frame 11 committed slot %0d after short sync", last_good);

      // Reset mid channel 5, coinciding with a valid strobe.
      send_frame(4'h9, 12, 5, 2, 1'b0);
      @(negedge clk);
      rst       = 1'b1;
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      @(negedge clk);
      #1;
      check_eq("mid_rst_we",     32'(ram_we),       32'd0);
      check_eq("mid_rst_addr",   32'(ram_addr),     32'd0);
      check_eq("mid_rst_idx",    32'(last_good),    32'd0);
      check_eq("mid_rst_user",   32'(user_bits),    32'd0);
      check_eq("mid_rst_locked", 32'(locked),       32'd0);
      check_eq("mid_rst_error",  32'(frame_error),  32'd0);
      check_eq("mid_rst_drain",  32'(exp_q.size()), 32'd0);
      rst       = 1'b0;
      bit_valid = 1'b0;
      exp_slot  = '0;
      send_frame(4'h3, 13, -1, 0, 1'b0);
      #1;
      check_eq("post_rst_idx",    32'(last_good), 32'd0);
      check_eq("post_rst_locked", 32'(locked),    32'd1);
      check_eq("post_rst_user",   32'(user_bits), 32'h3);
      $display("frame 13 committed slot %0d after reset", last_good);

      // Loss of signal: 15 zeros drop lock without an error pulse.
      repeat (15) send_bit(1'b0);
      #1;
      check_eq("los_still_locked", 32'(locked), 32'd1);
      idle();
      #1;
      check_eq("los_unlocked", 32'(locked),      32'd0);
      check_eq("los_no_error", 32'(frame_error), 32'd0);
      check_eq("los_idx_hold", 32'(last_good),   32'd0);
      repeat (2) idle();
      #1;
      check_eq("error_pulses", 32'(err_seen),     32'd1);
      check_eq("final_drain",  32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
